// File: rtl/mem_seq_pkg.sv
// Shared types for the memory sequencer: FSM state encoding
// and the NOP instruction presented to the core after reset.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        DATA,
        COMMIT,
        HALT
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_sequencer_if.sv
// Single-port memory bus between sequencer and RAM.
// Ports: mem_req/mem_we/mem_addr/mem_wdata (master out),
//        mem_rdata/mem_ready (slave out).
interface mem_sequencer_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/mem_sequencer_wait_timer.sv
// Saturating bus wait counter with a timeout flag.
// Ports: clock, reset, clear, enable in; expire out.
module wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW =
        (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] MAXC = CW'(WAIT_LIMIT);
    localparam logic [CW-1:0] LAST =
        CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
    localparam bit ARMED = (WAIT_LIMIT > 0);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != MAXC) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the waiting cycle that brings the count to the
    // limit, so the FSM leaves on that same edge.
    assign expire = ARMED && enable && (count >= LAST);

endmodule

// File: rtl/mem_sequencer.sv
// Shares one single-port RAM between instruction fetch and
// load/store, holding instruction and load data for the core.
// Ports: clock, reset, pc, instruction, d_addr, d_wdata, d_re,
//        d_we, d_rdata, cpu_step, bus_error, bus (memory master).
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      pc,
    output logic [31:0]      instruction,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    input  logic             d_re,
    input  logic             d_we,
    output logic [31:0]      d_rdata,
    output logic             cpu_step,
    output logic             bus_error,
    mem_sequencer_if.master  bus
);

    state_t      state;
    state_t      state_nxt;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        step;
    logic        accept;
    logic        timeout;

    assign accept = bus.mem_req && bus.mem_ready;

    wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (bus.mem_ready || (state_nxt != state)),
        .enable (bus.mem_req && !bus.mem_ready),
        .expire (timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (timeout) begin
                    state_nxt = HALT;
                end else if (bus.mem_ready) begin
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                state_nxt = (d_re || d_we) ? DATA : FETCH;
            end
            DATA: begin
                if (timeout) begin
                    state_nxt = HALT;
                end else if (bus.mem_ready) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = FETCH;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_comb begin
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        step  = 1'b0;
        unique case (state)
            FETCH: begin
                req  = 1'b1;
                addr = pc;
            end
            DECODE: begin
                step = !(d_re || d_we);
            end
            DATA: begin
                req   = 1'b1;
                we    = d_we;
                addr  = d_addr;
                wdata = d_wdata;
            end
            COMMIT: begin
                step = 1'b1;
            end
            HALT: begin
                step = 1'b0;
            end
            default: begin
                step = 1'b0;
            end
        endcase
    end

    // Withdraw any request and suppress commit during reset.
    assign bus.mem_req   = req && !reset;
    assign bus.mem_we    = we && !reset;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign cpu_step      = step && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            instruction <= NOP_INSN;
            d_rdata     <= '0;
            bus_error   <= 1'b0;
        end else begin
            if (state == FETCH && accept) begin
                instruction <= bus.mem_rdata;
            end
            // Conflicting load+store resolves as a store.
            if (state == DATA && accept && !d_we) begin
                d_rdata <= bus.mem_rdata;
            end
            if (timeout) begin
                bus_error <= 1'b1;
            end
            if (state == DECODE && d_re && d_we) begin
                bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a scripted memory.
// Ports: none; drives the DUT and the bus interface directly.
module tb_mem_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] instruction;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_rdata;
    logic        cpu_step;
    logic        bus_error;

    int vecs = 0;
    int errs = 0;

    mem_sequencer_if bus ();

    mem_sequencer #(
        .WAIT_LIMIT(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_re        (d_re),
        .d_we        (d_we),
        .d_rdata     (d_rdata),
        .cpu_step    (cpu_step),
        .bus_error   (bus_error),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench in cycle 1 after reset release.
    task automatic do_reset;
        reset = 1'b1;
        d_re = 1'b0;
        d_we = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clock);
        #1;
        vecs++;
        if (bus.mem_req !== 1'b0) begin
            errs++;
            $display("FAIL rst_req got %b want 0", bus.mem_req);
        end
        vecs++;
        if (cpu_step !== 1'b0) begin
            errs++;
            $display("FAIL rst_step got %b want 0", cpu_step);
        end
        vecs++;
        if (instruction !== 32'h0000_0013) begin
            errs++;
            $display("FAIL rst_insn got %h want 00000013",
                     instruction);
        end
        vecs++;
        if (d_rdata !== 32'h0 || bus_error !== 1'b0) begin
            errs++;
            $display("FAIL rst_regs got %h/%b want 0/0",
                     d_rdata, bus_error);
        end
    endtask

    task automatic test_alu;
        do_reset();
        pc = 32'h0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0050_0093;
        #1;
        vecs++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 ||
            bus.mem_we !== 1'b0 || cpu_step !== 1'b0) begin
            errs++;
            $display("FAIL alu_c1 got req%b we%b a%h s%b want 1 0 0 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, cpu_step);
        end
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        vecs++;
        if (instruction !== 32'h0050_0093 || cpu_step !== 1'b1 ||
            bus.mem_req !== 1'b0) begin
            errs++;
            $display("FAIL alu_c2 got %h s%b r%b want 00500093 1 0",
                     instruction, cpu_step, bus.mem_req);
        end
        tick();
        bus.mem_ready = 1'b0;
        #1;
        vecs++;
        if (bus.mem_req !== 1'b1 || cpu_step !== 1'b0 ||
            instruction !== 32'h0050_0093) begin
            errs++;
            $display("FAIL alu_c3 got r%b s%b %h want 1 0 00500093",
                     bus.mem_req, cpu_step, instruction);
        end
    endtask

    task automatic test_load_wait;
        do_reset();
        pc = 32'h8;
        d_re = 1'b1;
        d_addr = 32'h100;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_2103;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        vecs++;
        if (bus.mem_req !== 1'b0 || cpu_step !== 1'b0) begin
            errs++;
            $display("FAIL ld_dec got r%b s%b want 0 0",
                     bus.mem_req, cpu_step);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.mem_ready = (i == 2);
            bus.mem_rdata = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            vecs++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 ||
                bus.mem_we !== 1'b0) begin
                errs++;
                $display("FAIL ld_data%0d got r%b a%h w%b want 1 100 0",
                         i, bus.mem_req, bus.mem_addr, bus.mem_we);
            end
        end
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        vecs++;
        if (d_rdata !== 32'hDEAD_BEEF || cpu_step !== 1'b1 ||
            bus.mem_req !== 1'b0) begin
            errs++;
            $display("FAIL ld_commit got %h s%b r%b want deadbeef 1 0",
                     d_rdata, cpu_step, bus.mem_req);
        end
        vecs++;
        if (instruction !== 32'h0000_2103) begin
            errs++;
            $display("FAIL ld_insn got %h want 00002103", instruction);
        end
        tick();
        d_re = 1'b0;
        #1;
        vecs++;
        if (bus.mem_req !== 1'b1 || cpu_step !== 1'b0 ||
            bus.mem_addr !== 32'h8) begin
            errs++;
            $display("FAIL ld_next got r%b s%b a%h want 1 0 8",
                     bus.mem_req, cpu_step, bus.mem_addr);
        end
    endtask

    // Continues from the FETCH left by test_load_wait.
    task automatic test_store;
        pc = 32'hC;
        d_we = 1'b1;
        d_addr = 32'h104;
        d_wdata = 32'h1234_5678;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0011_2223;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        vecs++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 ||
            bus.mem_addr !== 32'h104 ||
            bus.mem_wdata !== 32'h1234_5678) begin
            errs++;
            $display("FAIL st_data got r%b w%b a%h d%h want 1 1 104 12345678",
                     bus.mem_req, bus.mem_we, bus.mem_addr,
                     bus.mem_wdata);
        end
        tick();
        bus.mem_ready = 1'b0;
        #1;
        vecs++;
        if (cpu_step !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL st_commit got s%b %h want 1 deadbeef",
                     cpu_step, d_rdata);
        end
        vecs++;
        if (bus_error !== 1'b0) begin
            errs++;
            $display("FAIL st_err got %b want 0", bus_error);
        end
        d_we = 1'b0;
    endtask

    task automatic test_timeout;
        do_reset();
        pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if (bus.mem_req !== 1'b1 || bus_error !== 1'b0) begin
                errs++;
                $display("FAIL to_wait%0d got r%b e%b want 1 0",
                         i, bus.mem_req, bus_error);
            end
            tick();
        end
        vecs++;
        if (bus_error !== 1'b1 || bus.mem_req !== 1'b0) begin
            errs++;
            $display("FAIL to_halt got e%b r%b want 1 0",
                     bus_error, bus.mem_req);
        end
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = i[0];
            tick();
            vecs++;
            if (cpu_step !== 1'b0 || bus.mem_req !== 1'b0) begin
                errs++;
                $display("FAIL to_stay%0d got s%b r%b want 0 0",
                         i, cpu_step, bus.mem_req);
            end
        end
        do_reset();
        #1;
        vecs++;
        if (bus_error !== 1'b0 || bus.mem_req !== 1'b1 ||
            bus.mem_addr !== 32'h40) begin
            errs++;
            $display("FAIL to_recover got e%b r%b a%h want 0 1 40",
                     bus_error, bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        pc = 32'h20;
        d_re = 1'b1;
        d_addr = 32'h200;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_2183;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        #1;
        vecs++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
            errs++;
            $display("FAIL rm_data got r%b a%h want 1 200",
                     bus.mem_req, bus.mem_addr);
        end
        tick();
        reset = 1'b1;
        #1;
        vecs++;
        if (bus.mem_req !== 1'b0 || cpu_step !== 1'b0) begin
            errs++;
            $display("FAIL rm_cycle got r%b s%b want 0 0",
                     bus.mem_req, cpu_step);
        end
        tick();
        vecs++;
        if (instruction !== 32'h0000_0013 || cpu_step !== 1'b0) begin
            errs++;
            $display("FAIL rm_insn got %h s%b want 00000013 0",
                     instruction, cpu_step);
        end
        d_re = 1'b0;
        reset = 1'b0;
        #1;
        vecs++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h20 ||
            bus.mem_we !== 1'b0 || cpu_step !== 1'b0) begin
            errs++;
            $display("FAIL rm_restart got r%b a%h w%b s%b want 1 20 0 0",
                     bus.mem_req, bus.mem_addr, bus.mem_we, cpu_step);
        end
    endtask

    task automatic test_both;
        do_reset();
        pc = 32'h30;
        d_re = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h108;
        d_wdata = 32'hCAFE_F00D;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        tick();
        bus.mem_ready = 1'b0;
        #1;
        vecs++;
        if (bus_error !== 1'b0 || cpu_step !== 1'b0) begin
            errs++;
            $display("FAIL both_dec got e%b s%b want 0 0",
                     bus_error, cpu_step);
        end
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        #1;
        vecs++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h108 ||
            bus.mem_wdata !== 32'hCAFE_F00D || bus_error !== 1'b1) begin
            errs++;
            $display("FAIL both_data got w%b a%h d%h e%b want 1 108 cafef00d 1",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus_error);
        end
        tick();
        bus.mem_ready = 1'b0;
        #1;
        vecs++;
        if (cpu_step !== 1'b1 || d_rdata !== 32'h0 ||
            bus_error !== 1'b1) begin
            errs++;
            $display("FAIL both_commit got s%b %h e%b want 1 0 1",
                     cpu_step, d_rdata, bus_error);
        end
        d_re = 1'b0;
        d_we = 1'b0;
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_timeout();
        test_reset_mid();
        test_both();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
